// File: rtl/frac_lutk_ccff.sv
// Fracturable K-input LUT with a serial configuration chain (2^K truth-table bits + mode bit).
// Define FRAC_LUTK_REG_OUT_EN to register the LUT outputs (one cycle of latency from in).
module frac_lutk_ccff #(
    parameter int K = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_en,
    input  logic         cfg_din,
    output logic         cfg_dout,
    output logic         cfg_done,
    input  logic [K-1:0] in,
    output logic [1:0]   lutk1_out,
    output logic         lutk_out
);
    localparam int N  = 1 << K;
    localparam int L  = N + 1;
    localparam int CW = $clog2(L + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t        state_q, state_d;
    logic [L-1:0]  chain_q, chain_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q;

    always_comb begin
        chain_d = chain_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (cfg_en) begin
            chain_d = {chain_q[L-2:0], cfg_din};
        end
        unique case (state_q)
            IDLE: begin
                if (cfg_en) begin
                    cnt_d   = CW'(1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cfg_en) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(L - 1)) begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                // A shift while DONE is the first bit of the next load.
                if (cfg_en) begin
                    cnt_d   = CW'(1);
                    state_d = LOAD;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            done_q  <= (state_d == DONE);
        end
    end

    assign cfg_dout = chain_q[L-1];
    assign cfg_done = done_q;

    logic [N-1:0] sram;
    logic         mode;
    logic [K-1:0] a_lo, a_hi, a_eff;
    logic [2:0]   lut_d;

    assign sram = chain_q[N-1:0];
    assign mode = chain_q[L-1];

    // Mode 1 forces the address MSB high so lutk_out follows the upper (K-1)-LUT.
    always_comb begin
        a_lo  = {1'b0, in[K-2:0]};
        a_hi  = {1'b1, in[K-2:0]};
        a_eff = {in[K-1] | mode, in[K-2:0]};
        lut_d = '0;
        if (done_q) begin
            lut_d = {sram[a_hi], sram[a_lo], sram[a_eff]};
        end
    end

`ifdef FRAC_LUTK_REG_OUT_EN
    logic [2:0] lut_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lut_q <= '0;
        end else begin
            lut_q <= lut_d;
        end
    end

    assign lutk1_out = lut_q[2:1];
    assign lutk_out  = lut_q[0];
`else
    assign lutk1_out = lut_d[2:1];
    assign lutk_out  = lut_d[0];
`endif

endmodule

// File: tb/tb_frac_lutk_ccff.sv
// Randomised self-checking bench for frac_lutk_ccff, driving a K=4 and a K=6 instance
// with the same configuration stream and comparing against a queue-based reference.
module tb_frac_lutk_ccff;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, cfg_en, cfg_din;
    logic [3:0] in4;
    logic [5:0] in6;
    logic       dout4, done4, lk4, dout6, done6, lk6;
    logic [1:0] lk14, lk16;

    int checks   = 0;
    int failures = 0;

    // Reference: each queue holds the last L bits shifted in, oldest (mode) at the front.
    bit         m4[$], m6[$], hist6[$];
    int         pos4, pos6;
    bit         dn4, dn6;
    logic [2:0] exp4, exp6;

    frac_lutk_ccff #(.K(4)) u_k4 (
        .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_din(cfg_din),
        .cfg_dout(dout4), .cfg_done(done4), .in(in4),
        .lutk1_out(lk14), .lutk_out(lk4)
    );

    frac_lutk_ccff #(.K(6)) u_k6 (
        .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_din(cfg_din),
        .cfg_dout(dout6), .cfg_done(done6), .in(in6),
        .lutk1_out(lk16), .lutk_out(lk6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // {lutk1_out[1], lutk1_out[0], lutk_out} from the loaded bits; sram[j] = q[L-1-j].
    function automatic logic [2:0] lut_ref(input int k, input bit q[$], input bit done, input int inv);
        int l, a_lo, a_hi, a_full, a;
        l = (1 << k) + 1;
        if (!done) return 3'b000;
        a_lo   = inv % (1 << (k - 1));
        a_hi   = a_lo + (1 << (k - 1));
        a_full = inv % (1 << k);
        a      = q[0] ? a_hi : a_full;
        return {logic'(q[l-1-a_hi]), logic'(q[l-1-a_lo]), logic'(q[l-1-a])};
    endfunction

    task automatic model_reset();
        m4 = {};
        m6 = {};
        hist6 = {};
        repeat (17) m4.push_back(1'b0);
        repeat (65) m6.push_back(1'b0);
        pos4 = 0; pos6 = 0; dn4 = 1'b0; dn6 = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit din);
        if (en) begin
            void'(m4.pop_front()); m4.push_back(din);
            void'(m6.pop_front()); m6.push_back(din);
            hist6.push_back(din);
            if (pos4 == 0 || dn4) begin pos4 = 1; dn4 = 1'b0; end else pos4++;
            if (pos4 == 17) dn4 = 1'b1;
            if (pos6 == 0 || dn6) begin pos6 = 1; dn6 = 1'b0; end else pos6++;
            if (pos6 == 65) dn6 = 1'b1;
        end else begin
            if (!dn4) pos4 = 0;
            if (!dn6) pos6 = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_dout4"}, 32'(dout4), 32'(m4[0]));
        check({tag, "_done4"}, 32'(done4), 32'(dn4));
        check({tag, "_lut4"},  32'({lk14, lk4}), 32'(exp4));
        check({tag, "_dout6"}, 32'(dout6), 32'(m6[0]));
        check({tag, "_done6"}, 32'(done6), 32'(dn6));
        check({tag, "_lut6"},  32'({lk16, lk6}), 32'(exp6));
    endtask

    task automatic cycle(input bit rst, input bit en, input bit din);
        logic [2:0] pre4, pre6;
        reset = rst; cfg_en = en; cfg_din = din;
        pre4 = lut_ref(4, m4, dn4, int'(in4));
        pre6 = lut_ref(6, m6, dn6, int'(in6));
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(en, din);
        #1;
`ifdef FRAC_LUTK_REG_OUT_EN
        exp4 = rst ? 3'b000 : pre4;
        exp6 = rst ? 3'b000 : pre6;
`else
        exp4 = lut_ref(4, m4, dn4, int'(in4));
        exp6 = lut_ref(6, m6, dn6, int'(in6));
`endif
    endtask

    // Changing in between edges: combinational build follows at once, registered build holds.
    task automatic set_in(input logic [3:0] v4, input logic [5:0] v6, input string tag);
        in4 = v4; in6 = v6;
        #1;
`ifndef FRAC_LUTK_REG_OUT_EN
        exp4 = lut_ref(4, m4, dn4, int'(in4));
        exp6 = lut_ref(6, m6, dn6, int'(in6));
`endif
        check_all(tag);
        cycle(1'b0, 1'b0, 1'b0);
        check_all(tag);
    endtask

    task automatic load4(input logic [16:0] bits, input string tag);
        for (int i = 16; i >= 0; i--) begin
            cycle(1'b0, 1'b1, bits[i]);
            check_all(tag);
        end
        check({tag, "_done_after17"}, 32'(done4), 32'd1);
    endtask

    initial begin
        logic [16:0] b;
        reset = 1'b1; cfg_en = 1'b1; cfg_din = 1'b1; in4 = '0; in6 = '0;
        model_reset();
        exp4 = '0; exp6 = '0;

        // Reset holds everything at zero even with cfg_en high
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        check_all("rst");
        check("rst_dout_const", 32'(dout4), 32'd0);
        check("rst_lut_const", 32'({lk14, lk4}), 32'd0);

        // Mode 0, only sram[15] set
        b = {1'b0, 16'h8000};
        load4(b, "m0");
        set_in(4'hF, 6'h00, "m0_inF");
        check("m0_inF_lutk", 32'(lk4), 32'd1);
        set_in(4'h7, 6'h00, "m0_in7");
        check("m0_in7_lutk", 32'(lk4), 32'd0);
`ifdef FRAC_LUTK_REG_OUT_EN
        in4 = 4'hF; #1;
        check("reg_latency_hold", 32'(lk4), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("reg_latency_rise", 32'(lk4), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        check("reg_reset_clear", 32'(lk4), 32'd0);
        check_all("reg_rst");
        load4(b, "m0r");
        cycle(1'b0, 1'b0, 1'b0);
`endif

        // Mode 1 with 16'hA5F0
        b = {1'b1, 16'hA5F0};
        load4(b, "m1");
        set_in(4'b0100, 6'h04, "m1_in4");
        check("m1_in4_lutk1", 32'(lk14), 32'd1);
        check("m1_in4_lutk", 32'(lk4), 32'd0);
        set_in(4'b1100, 6'h24, "m1_inC");
        check("m1_inC_lutk", 32'(lk4), 32'd0);

        // Abort after 9 shifts, then a complete load
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, 1'($urandom));
            check_all("abort_shift");
        end
        cycle(1'b0, 1'b0, 1'b0);
        check_all("abort");
        check("abort_done", 32'(done4), 32'd0);
        check("abort_lut", 32'({lk14, lk4}), 32'd0);
        b = 17'($urandom);
        load4(b, "reload");
        for (int i = 0; i < 8; i++) set_in(4'($urandom), 6'($urandom), "reload_in");

        // Cascade / overflow on the K=6 instance
        cycle(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 130; n++) begin
            cycle(1'b0, 1'b1, 1'($urandom));
            check_all("casc");
            if (n >= 65) check("casc_dout_order", 32'(dout6), 32'(hist6[n-65]));
            if (n == 65)  check("casc_done65", 32'(done6), 32'd1);
            if (n == 66)  check("casc_done66", 32'(done6), 32'd0);
            if (n == 130) check("casc_done130", 32'(done6), 32'd1);
        end
        for (int i = 0; i < 8; i++) set_in(4'($urandom), 6'($urandom), "casc_in");

        // Free-running random traffic with occasional resets and pauses
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in4 = 4'($urandom); in6 = 6'($urandom);
            end
            cycle(($urandom_range(0, 80) == 0), ($urandom_range(0, 15) != 0), 1'($urandom));
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frac_lutk_ccff.md
Name: frac_lutk_ccff

Overview:
- Parametrised K-input fracturable LUT with its own configuration chain: 2^K truth-table bits plus 1 mode bit, loaded serially.
- Mode 0 gives one K-LUT. Mode 1 gives two (K-1)-LUTs sharing inputs in[K-2:0].
- Sits in the CLB logic element and is daisy-chained with neighbouring blocks through cfg_din/cfg_dout.
- Adds in-block config loading, load-progress tracking and output gating, which the fixed 4-input version lacks.

Parameters:
K, 6, LUT input count; legal range 3..8.
L (localparam), 2^K+1, configuration chain length.
CW (localparam), $clog2(L+1), shift-counter width.

Ports:
clk  input  1  single clock for chain, FSM and optional output regs
reset  input  1  synchronous, active-high reset
cfg_en  input  1  shift enable; one chain bit per clk while high
cfg_din  input  1  serial config input
cfg_dout  output  1  serial config output = chain[L-1], to next block
cfg_done  output  1  high while a complete, unaborted load is held
in  input  K  LUT inputs; in[0] is address LSB
lutk1_out  output  2  fractured (K-1)-LUT outputs
lutk_out  output  1  K-LUT output

Behaviour:
- Chain: register chain[L-1:0].
  - On clk with cfg_en=1: chain[0]<=cfg_din and chain[i]<=chain[i-1].
  - cfg_dout=chain[L-1], driven directly from the register.
  - Bit map: chain[2^K-1:0]=sram[2^K-1:0]; chain[L-1]=mode.
  - Load order: mode first, then sram[2^K-1] down to sram[0].
- FSM states and transitions:
  - IDLE (reset state): cfg_en=1 -> shift, cnt<=1, go to LOAD.
  - LOAD: cfg_en=1 -> shift, cnt<=cnt+1; when this shift makes cnt==L, go to DONE.
  - LOAD: cfg_en=0 with cnt<L -> abort to IDLE, cnt<=0. Chain contents are kept but not trusted.
  - DONE: cfg_en=1 -> restart. This shift is bit 1 of a new load: cnt<=1, go to LOAD.
  - DONE: cfg_en=0 -> hold.
- cfg_done=(state==DONE), registered. It rises on the clk edge that performs the L-th shift.
- LUT function, addresses:
  - A_lo={1'b0,in[K-2:0]}; A_hi={1'b1,in[K-2:0]}; A_full=in[K-1:0].
  - Effective MSB = in[K-1] OR mode.
- LUT function, outputs when state==DONE:
  - lutk1_out[0]=sram[A_lo] and lutk1_out[1]=sram[A_hi], in both modes.
  - mode=0: lutk_out=sram[A_full].
  - mode=1: lutk_out=sram[A_hi], i.e. in[K-1] is ignored.
- Gating: while state!=DONE, lutk_out=0 and lutk1_out=2'b00. Partially shifted contents never reach logic.
- Reset: chain<=0, cnt<=0, state<=IDLE. cfg_dout=0, cfg_done=0, all LUT outputs 0.
  - Reset mid-load discards progress.
  - reset overrides cfg_en in the same cycle.
- Extra bits: shifts past L start a new load, and bits continue out through cfg_dout. Chain cascades stay length-exact.
- No X on outputs after reset for any in value.

Optional Feature:
- Macro: FRAC_LUTK_REG_OUT_EN.
- Defined:
  - lutk_out and lutk1_out are registered on clk: 1-cycle latency from in to output.
  - Registers reset to 0 synchronously.
  - Gating is applied before the register, so outputs read 0 on the cycle after leaving DONE.
  - cfg_dout and cfg_done are unaffected.
- Undefined: outputs are combinational from in, chain and state, with zero latency.

Test Plan:
1. Reset check, K=4 (L=17): assert reset 2 cycles with cfg_en=1 and cfg_din=1 -> cfg_dout=0, cfg_done=0, lutk_out=0, lutk1_out=00, state IDLE.
2. Mode-0 load, K=4: shift mode=0 then sram=16'h8000 (sram[15] first), 17 cycles -> cfg_done rises on the 17th edge; in=4'hF gives lutk_out=1; in=4'h7 gives lutk_out=0.
3. Mode-1 load, K=4: mode=1, sram=16'hA5F0 ->
   - in=4'b0100 (A_lo=4, A_hi=12): lutk1_out[0]=1, lutk1_out[1]=0.
   - in=4'b1100: lutk_out=sram[12]=0, identical to in=4'b0100.
4. Abort: drop cfg_en after 9 shifts -> state IDLE, cfg_done=0, outputs 0. A fresh 17-shift load then completes normally.
5. Cascade/overflow, K=6 (L=65): shift 130 bits -> the first 65 bits appear on cfg_dout from cycle 65 onward in order; cfg_done toggles 1 at shift 65, 0 at shift 66, 1 at shift 130.
6. With FRAC_LUTK_REG_OUT_EN, after case 2: change in from 4'h7 to 4'hF -> lutk_out rises exactly one clk later. Reset mid-DONE clears it on the next edge.
